// File: rtl/multi_digit_led_scroller_pkg.sv
// Shared display constants and the hex-to-seven-segment decoder.
package led_disp_pkg;

    // Active-high segment patterns, bit order abcdefg on [6:0].
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h1F;
    localparam logic [6:0] SEG_C = 7'h4E;
    localparam logic [6:0] SEG_D = 7'h3D;
    localparam logic [6:0] SEG_E = 7'h4F;
    localparam logic [6:0] SEG_F = 7'h47;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // Returns the active-low segment drive for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = SEG_0;
            4'h1:    pat = SEG_1;
            4'h2:    pat = SEG_2;
            4'h3:    pat = SEG_3;
            4'h4:    pat = SEG_4;
            4'h5:    pat = SEG_5;
            4'h6:    pat = SEG_6;
            4'h7:    pat = SEG_7;
            4'h8:    pat = SEG_8;
            4'h9:    pat = SEG_9;
            4'hA:    pat = SEG_A;
            4'hB:    pat = SEG_B;
            4'hC:    pat = SEG_C;
            4'hD:    pat = SEG_D;
            4'hE:    pat = SEG_E;
            default: pat = SEG_F;
        endcase
        return ~pat;
    endfunction

endpackage

// File: rtl/multi_digit_led_scroller_debouncer.sv
// Two-flop synchroniser plus stability counter for a raw push-button.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_stable,
    output logic rise_pulse
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] dcnt_q;
    logic          stable_q;
    logic          rise_q;

    // Synchronise, count consecutive differing cycles, accept the new level at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            dcnt_q   <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            if (sync2_q != stable_q) begin
                if (dcnt_q == CNT_LAST) begin
                    stable_q <= sync2_q;
                    dcnt_q   <= '0;
                    rise_q   <= sync2_q;
                end else begin
                    dcnt_q <= dcnt_q + 1'b1;
                end
            end else begin
                dcnt_q <= '0;
            end
        end
    end

    assign btn_stable = stable_q;
    assign rise_pulse = rise_q;

endmodule

// File: rtl/multi_digit_led_scroller.sv
// N-digit multiplexed seven-segment driver with manual or automatic message scrolling.
module multi_digit_led_scroller
    import led_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned NUM_CHARS       = 16,
    parameter int unsigned REFRESH_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES    = 500,
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned SCROLL_DIV      = 25000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        btn,
    input  logic                        mode,
    input  logic [4*NUM_CHARS-1:0]      msg,
    output logic [NUM_DIGITS-1:0]       an,
    output logic [6:0]                  seg,
    output logic                        dp,
    output logic                        refresh_tick,
    output logic                        btn_stable,
    output logic [((NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1)-1:0] ptr
);

    localparam int unsigned PW   = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam int unsigned DW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned RW   = $clog2(REFRESH_DIV);
    localparam int unsigned SW   = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int unsigned SUMW = $clog2(NUM_CHARS + NUM_DIGITS) + 1;

    localparam logic [RW-1:0] RCNT_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [RW-1:0] BLANK_LIM  = RW'(BLANK_CYCLES);
    localparam logic [DW-1:0] DSEL_LAST  = DW'(NUM_DIGITS - 1);
    localparam logic [SW-1:0] SCNT_LAST  = SW'(SCROLL_DIV - 1);
    localparam logic [PW-1:0] PTR_LAST   = PW'(NUM_CHARS - 1);

    logic [RW-1:0]         rcnt_q;
    logic [DW-1:0]         dsel_q;
    logic                  tick_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]            seg_q;
    logic                  dp_q;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          pause_q, pause_d;
    logic          mode_q;

    logic          btn_step;
    logic [PW-1:0] ptr_adv;
    logic          scroll_wrap;

    logic [3:0]            chars [NUM_CHARS];
    logic [SUMW-1:0]       char_sum;
    logic [PW-1:0]         char_idx;
    logic [NUM_DIGITS-1:0] an_d;
    logic [6:0]            seg_d;
    logic                  dp_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn),
        .btn_stable (btn_stable),
        .rise_pulse (btn_step)
    );

    for (genvar k = 0; k < NUM_CHARS; k++) begin : g_chars
        assign chars[k] = msg[4*k +: 4];
    end

    // Slot timer: advances the selected digit and flags the slot change.
    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt_q <= '0;
            dsel_q <= '0;
            tick_q <= 1'b0;
        end else if (rcnt_q == RCNT_LAST) begin
            rcnt_q <= '0;
            dsel_q <= (dsel_q == DSEL_LAST) ? '0 : dsel_q + 1'b1;
            tick_q <= 1'b1;
        end else begin
            rcnt_q <= rcnt_q + 1'b1;
            tick_q <= 1'b0;
        end
    end

    // Picks the character for the current digit and forms the anode/segment drive.
    always_comb begin
        char_sum = SUMW'(ptr_q) + SUMW'(NUM_DIGITS - 1) - SUMW'(dsel_q);
        char_idx = PW'(char_sum % SUMW'(NUM_CHARS));
        seg_d    = hex_to_seg(chars[char_idx]);
        dp_d     = (char_idx != '0);
        if (rcnt_q < BLANK_LIM) begin
            an_d = '1;
        end else begin
            an_d = ~(NUM_DIGITS'(1) << dsel_q);
        end
    end

    // Display output registers; anode and segments update on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q  <= '1;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign ptr_adv = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;

    // Scroll/pause next state; in auto mode a press also restarts the scroll period,
    // so a resume waits a full period and a press colliding with a wrap suppresses the step.
    always_comb begin
        ptr_d       = ptr_q;
        scnt_d      = scnt_q;
        pause_d     = pause_q;
        scroll_wrap = 1'b0;
        if (mode != mode_q) begin
            scnt_d  = '0;
            pause_d = 1'b0;
        end else if (mode == MODE_MANUAL) begin
            scnt_d = '0;
            if (btn_step) begin
                ptr_d = ptr_adv;
            end
        end else begin
            scroll_wrap = !pause_q && (scnt_q == SCNT_LAST);
            if (btn_step) begin
                pause_d = ~pause_q;
                scnt_d  = '0;
            end else if (scroll_wrap) begin
                scnt_d = '0;
                ptr_d  = ptr_adv;
            end else if (!pause_q) begin
                scnt_d = scnt_q + 1'b1;
            end
        end
    end

    // Scroll state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            scnt_q  <= '0;
            pause_q <= 1'b0;
            mode_q  <= MODE_MANUAL;
        end else begin
            ptr_q   <= ptr_d;
            scnt_q  <= scnt_d;
            pause_q <= pause_d;
            mode_q  <= mode;
        end
    end

    assign an           = an_q;
    assign seg          = seg_q;
    assign dp           = dp_q;
    assign refresh_tick = tick_q;
    assign ptr          = ptr_q;

endmodule

// File: tb/tb_multi_digit_led_scroller.sv
// Vector tables plus scoreboarded sequences for the LED scroller.
module tb_multi_digit_led_scroller;

    localparam int ND = 4;
    localparam int NC = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn;
    logic        mode;
    logic [23:0] msg;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        refresh_tick;
    logic        btn_stable;
    logic [2:0]  ptr;

    multi_digit_led_scroller #(
        .NUM_DIGITS      (ND),
        .NUM_CHARS       (NC),
        .REFRESH_DIV     (8),
        .BLANK_CYCLES    (2),
        .DEBOUNCE_CYCLES (4),
        .SCROLL_DIV      (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn),
        .mode         (mode),
        .msg          (msg),
        .an           (an),
        .seg          (seg),
        .dp           (dp),
        .refresh_tick (refresh_tick),
        .btn_stable   (btn_stable),
        .ptr          (ptr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        int unsigned val;
    } exp_t;
    exp_t sb_q[$];

    typedef struct packed {
        logic [23:0] msg;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;
    vec_t vt [24];

    function automatic void check(string name, int unsigned act, int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    function automatic void sb_push(string name, int unsigned v);
        exp_t e;
        e.name = name;
        e.val  = v;
        sb_q.push_back(e);
    endfunction

    function automatic void sb_pop(int unsigned act);
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got %0h want queued entry", act);
        end else begin
            e = sb_q.pop_front();
            check(e.name, act, e.val);
        end
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_an(input logic [3:0] target);
        int k = 0;
        while (an != target && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (an != target) begin
            total++;
            bad++;
            $display("FAIL an_timeout: got %0h want %0h", an, target);
        end
    endtask

    task automatic apply_vec(input int i);
        msg = vt[i].msg;
        @(negedge clk);
        sb_push("vec_seg", 32'(vt[i].seg));
        sb_push("vec_dp", 32'(vt[i].dp));
        wait_an(vt[i].an);
        sb_pop(32'(seg));
        sb_pop(32'(dp));
    endtask

    task automatic press();
        btn = 1'b1;
        cyc(10);
        btn = 1'b0;
        cyc(10);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [6:0]  hexexp [16];
        logic [3:0]  an_exp;
        int          first_hi;
        int unsigned p6, p7;
        bit          ok;

        hexexp = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                   7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
        // ptr = 0: digits 3..0 show chars 0..3
        vt[0] = '{24'h543210, 4'h7, 7'h01, 1'b0};
        vt[1] = '{24'h543210, 4'hB, 7'h4F, 1'b1};
        vt[2] = '{24'h543210, 4'hD, 7'h12, 1'b1};
        vt[3] = '{24'h543210, 4'hE, 7'h06, 1'b1};
        // ptr = 4: digits 3..0 show chars 4,5,0,1
        vt[4] = '{24'h543210, 4'h7, 7'h4C, 1'b1};
        vt[5] = '{24'h543210, 4'hB, 7'h24, 1'b1};
        vt[6] = '{24'h543210, 4'hD, 7'h01, 1'b0};
        vt[7] = '{24'h543210, 4'hE, 7'h4F, 1'b1};
        for (int v = 0; v < 16; v++) begin
            vt[8+v] = '{{20'h54321, 4'(v)}, 4'h7, hexexp[v], 1'b0};
        end

        reset = 1'b1;
        btn   = 1'b0;
        mode  = 1'b0;
        msg   = 24'h543210;

        // Reset state
        cyc(2);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 1);
        check("rst_ptr", 32'(ptr), 0);
        check("rst_tick", 32'(refresh_tick), 0);
        check("rst_btn_stable", 32'(btn_stable), 0);
        cyc(18);
        check("rst_an_late", 32'(an), 32'hF);

        // Refresh sequence after release
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            an_exp = ((k % 8) < 2) ? 4'hF : ~(4'b0001 << ((k / 8) % 4));
            sb_push("refresh_an", 32'(an_exp));
            sb_push("refresh_tick", ((k % 8) == 7) ? 1 : 0);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            sb_pop(32'(an));
            sb_pop(32'(refresh_tick));
        end

        // Decode with ptr = 0, then every hex digit on digit 3
        for (int i = 0; i < 4; i++) apply_vec(i);
        for (int i = 8; i < 24; i++) apply_vec(i);
        msg = 24'h543210;
        cyc(1);

        // Bounce rejection
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            btn = (i % 2 == 0);
            cyc(2);
            if (btn_stable !== 1'b0 || ptr !== 3'd0) ok = 1'b0;
        end
        check("bounce_no_accept", 32'(ok), 1);
        btn = 1'b1;
        first_hi = -1;
        p6 = 0;
        p7 = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (first_hi < 0 && btn_stable) first_hi = k;
            if (k == 6) p6 = 32'(ptr);
            if (k == 7) p7 = 32'(ptr);
        end
        check("debounce_latency", 32'(first_hi), 6);
        check("bounce_ptr_before", p6, 0);
        check("bounce_ptr_step", p7, 1);
        btn = 1'b0;
        cyc(10);
        check("bounce_release", 32'(btn_stable), 0);
        check("bounce_ptr_once", 32'(ptr), 1);

        // Manual wrap from a fresh reset
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        for (int p = 1; p <= 6; p++) begin
            sb_push("manual_ptr", 32'(p % NC));
            press();
            sb_pop(32'(ptr));
            if (p == 4) begin
                for (int i = 4; i < 8; i++) apply_vec(i);
            end
        end

        // Auto scroll
        mode = 1'b1;
        cyc(32);
        check("auto_hold0", 32'(ptr), 0);
        cyc(1);
        check("auto_step1", 32'(ptr), 1);
        cyc(31);
        check("auto_hold1", 32'(ptr), 1);
        cyc(1);
        check("auto_step2", 32'(ptr), 2);
        cyc(32);
        check("auto_step3", 32'(ptr), 3);
        cyc(1);

        // Pause for 200 cycles
        btn = 1'b1;
        ok = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 10) btn = 1'b0;
            if (ptr !== 3'd3) ok = 1'b0;
        end
        check("pause_hold", 32'(ok), 1);

        // Resume: first step 32 cycles after the step edge
        btn = 1'b1;
        p6 = 0;
        p7 = 0;
        for (int k = 1; k <= 39; k++) begin
            @(negedge clk);
            if (k == 10) btn = 1'b0;
            if (k == 38) p6 = 32'(ptr);
            if (k == 39) p7 = 32'(ptr);
        end
        check("resume_before", p6, 3);
        check("resume_step", p7, 4);

        // Press landing on a scroll wrap: pause, no step
        cyc(25);
        btn = 1'b1;
        ok = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 10) btn = 1'b0;
            if (ptr !== 3'd4) ok = 1'b0;
        end
        check("collision_hold", 32'(ok), 1);

        // Mode toggle clears pause; scrolling restarts
        mode = 1'b0;
        cyc(1);
        check("mode_manual_ptr", 32'(ptr), 4);
        mode = 1'b1;
        cyc(32);
        check("mode_auto_hold", 32'(ptr), 4);
        cyc(1);
        check("mode_auto_step", 32'(ptr), 5);

        // Reset mid-slot
        wait_an(4'hB);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_ptr", 32'(ptr), 0);
        check("midrst_seg", 32'(seg), 32'h7F);
        check("midrst_dp", 32'(dp), 1);
        reset = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
